mem_req_arb: RTL and testbench

//  Memory-network request arbiter between the I$/D$ miss-handling paths and the memory controller.

---
 rtl/mem_req_arb_pkg.sv | 59 +++++
 rtl/mem_ret_tag_fifo.sv | 73 +++++++
 rtl/mem_req_arb.sv | 207 ++++++++++++++++++++
 tb/tb_mem_req_arb.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_arb_pkg.sv
// Shared memory-interface types for the request arbiter.
// Request buffers carry {we,tid,addr,parity}; return tags carry
// {rid,tid,ret_index,write,parity}; the memctrl command is {rid,tid,addr,we}.
package mem_req_arb_pkg;

    localparam int unsigned NTHREADIDMSB = 2;
    localparam int unsigned TID_W        = NTHREADIDMSB + 1;
    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned DATA_W       = 64;
    localparam int unsigned IDX_LSB      = 6;   // 64-byte bursts
    localparam int unsigned IDX_W        = 6;

    localparam logic RID_IMEM = 1'b0;
    localparam logic RID_DMEM = 1'b1;

    typedef struct packed {
        logic clk;
    } iu_clk_type;

    typedef struct packed {
        logic              we;
        logic [TID_W-1:0]  tid;
        logic [ADDR_W-1:0] addr;
        logic              parity;
    } imem_req_addr_buf_type;

    typedef struct packed {
        logic              we;
        logic [TID_W-1:0]  tid;
        logic [ADDR_W-1:0] addr;
        logic              parity;
    } dmem_req_addr_buf_type;

    typedef logic [DATA_W-1:0] imem_req_data_buf_type;
    typedef logic [DATA_W-1:0] dmem_req_data_buf_type;
    typedef logic [DATA_W-1:0] cache_data_type;

    typedef struct packed {
        logic             rid;
        logic [TID_W-1:0] tid;
        logic [IDX_W-1:0] ret_index;
        logic             write;
        logic             parity;
    } mem_ret_buf_type;

    typedef struct packed {
        logic              rid;
        logic [TID_W-1:0]  tid;
        logic [ADDR_W-1:0] addr;
        logic              we;
    } mem_arb_cmd_type;

    // Even parity bit over the request header.
    function automatic logic req_parity(input logic we, input logic [TID_W-1:0] tid,
                                        input logic [ADDR_W-1:0] addr);
        return ^{we, tid, addr};
    endfunction

endpackage

// File: rtl/mem_ret_tag_fifo.sv
// Return-tag FIFO: DEPTH entries of mem_ret_buf_type, pointers wrap modulo
// DEPTH, full/empty derived from an occupancy count.
// Ports: clk, rst (sync, active-high), push/wdata, pop, head (entry at read
// pointer), full, empty.
module mem_ret_tag_fifo
    import mem_req_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  mem_ret_buf_type wdata,
    input  logic            pop,
    output mem_ret_buf_type head,
    output logic            full,
    output logic            empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    mem_ret_buf_type ram [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = ram[rd_ptr_q];

    // Pointer wrap and occupancy update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, no reset (maps to distributed RAM).
    always_ff @(posedge clk) begin
        if (do_push) begin
            ram[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/mem_req_arb.sv
// Memory request arbiter: round-robins imem/dmem requests into one memctrl
// command stream under credit flow control, tags each command, and steers
// in-order memctrl results back to the requestor.
// Ports: gclk (gclk.clk only clock), rst (sync, active-high); i_/d_req_*
// request side with combinational *_req_ready; mc_req_* registered command;
// mc_credit credit pulses; mc_res_* results; i_/d_ret_valid, ret_* registered
// return; err sticky error.
// Optional feature: define MEMARB_PARITY_CHK_EN to check request parity and
// drop bad requests.
module mem_req_arb
    import mem_req_arb_pkg::*;
#(
    parameter int unsigned NCREDIT  = 4,
    parameter int unsigned TAGDEPTH = 8
) (
    input  iu_clk_type            gclk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    input  imem_req_addr_buf_type i_req,
    input  imem_req_data_buf_type i_req_data,
    output logic                  i_req_ready,
    input  logic                  d_req_valid,
    input  dmem_req_addr_buf_type d_req,
    input  dmem_req_data_buf_type d_req_data,
    output logic                  d_req_ready,
    output logic                  mc_req_valid,
    output mem_arb_cmd_type       mc_req,
    output dmem_req_data_buf_type mc_req_data,
    input  logic                  mc_credit,
    input  logic                  mc_res_valid,
    input  cache_data_type        mc_res_data,
    output logic                  i_ret_valid,
    output logic                  d_ret_valid,
    output logic [NTHREADIDMSB:0] ret_tid,
    output logic                  ret_write,
    output cache_data_type        ret_data,
    output logic                  err
);

    localparam int unsigned CW = $clog2(NCREDIT + 1);

    logic clk;
    assign clk = gclk.clk;

    logic [CW-1:0]         credit_q, credit_d;
    logic                  rr_last_q, rr_last_d;
    logic                  mc_req_valid_q, mc_req_valid_d;
    mem_arb_cmd_type       mc_req_q, mc_req_d;
    dmem_req_data_buf_type mc_req_data_q, mc_req_data_d;
    logic                  i_ret_valid_q, i_ret_valid_d;
    logic                  d_ret_valid_q, d_ret_valid_d;
    logic [TID_W-1:0]      ret_tid_q, ret_tid_d;
    logic                  ret_write_q, ret_write_d;
    cache_data_type        ret_data_q, ret_data_d;
    logic                  err_q, err_d;

    logic            i_par_bad, d_par_bad;
    logic            i_drop, d_drop;
    logic            can_issue, i_elig, d_elig;
    logic            i_grant, d_grant, grant;
    logic            credit_ovf;
    logic            tag_full, tag_empty, tag_pop;
    mem_ret_buf_type tag_wdata, tag_head;
    logic            unused_tag_bits;

`ifdef MEMARB_PARITY_CHK_EN
    assign i_par_bad = (i_req.parity != req_parity(i_req.we, i_req.tid, i_req.addr));
    assign d_par_bad = (d_req.parity != req_parity(d_req.we, d_req.tid, d_req.addr));
`else
    assign i_par_bad = 1'b0;
    assign d_par_bad = 1'b0;
`endif

    // Eligibility and round-robin grant; a tie goes to the side that did not win last.
    always_comb begin
        can_issue = !rst && (credit_q != '0) && !tag_full;
        i_elig    = i_req_valid && !i_par_bad && can_issue;
        d_elig    = d_req_valid && !d_par_bad && can_issue;
        i_grant   = i_elig && (!d_elig || (rr_last_q == RID_DMEM));
        d_grant   = d_elig && (!i_elig || (rr_last_q == RID_IMEM));
    end

    // Bad-parity requests are acknowledged and discarded.
    assign i_drop      = !rst && i_req_valid && i_par_bad;
    assign d_drop      = !rst && d_req_valid && d_par_bad;
    assign grant       = i_grant || d_grant;
    assign i_req_ready = i_grant || i_drop;
    assign d_req_ready = d_grant || d_drop;
    assign tag_pop     = mc_res_valid && !tag_empty;

    always_comb begin
        if (d_grant) begin
            tag_wdata = '{rid: RID_DMEM, tid: d_req.tid,
                          ret_index: d_req.addr[IDX_LSB +: IDX_W],
                          write: d_req.we, parity: d_req.parity};
        end else begin
            tag_wdata = '{rid: RID_IMEM, tid: i_req.tid,
                          ret_index: i_req.addr[IDX_LSB +: IDX_W],
                          write: i_req.we, parity: i_req.parity};
        end
    end

    mem_ret_tag_fifo #(
        .DEPTH (TAGDEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (grant),
        .wdata (tag_wdata),
        .pop   (tag_pop),
        .head  (tag_head),
        .full  (tag_full),
        .empty (tag_empty)
    );

    // Command, credit, return and error next-state.
    always_comb begin
        credit_d       = credit_q;
        rr_last_d      = rr_last_q;
        mc_req_valid_d = grant;
        mc_req_d       = mc_req_q;
        mc_req_data_d  = mc_req_data_q;
        i_ret_valid_d  = 1'b0;
        d_ret_valid_d  = 1'b0;
        ret_tid_d      = ret_tid_q;
        ret_write_d    = ret_write_q;
        ret_data_d     = ret_data_q;
        credit_ovf     = 1'b0;

        if (i_grant) begin
            mc_req_d      = '{rid: RID_IMEM, tid: i_req.tid, addr: i_req.addr, we: i_req.we};
            mc_req_data_d = i_req_data;
            rr_last_d     = RID_IMEM;
        end else if (d_grant) begin
            mc_req_d      = '{rid: RID_DMEM, tid: d_req.tid, addr: d_req.addr, we: d_req.we};
            mc_req_data_d = d_req_data;
            rr_last_d     = RID_DMEM;
        end

        // A credit and a grant in the same cycle cancel out.
        case ({mc_credit, grant})
            2'b10: begin
                if (credit_q == CW'(NCREDIT)) begin
                    credit_ovf = 1'b1;
                end else begin
                    credit_d = credit_q + CW'(1);
                end
            end
            2'b01:   credit_d = credit_q - CW'(1);
            default: credit_d = credit_q;
        endcase

        if (mc_res_valid) begin
            ret_data_d = mc_res_data;
        end
        if (tag_pop) begin
            i_ret_valid_d = (tag_head.rid == RID_IMEM);
            d_ret_valid_d = (tag_head.rid == RID_DMEM);
            ret_tid_d     = tag_head.tid;
            ret_write_d   = tag_head.write;
        end

        err_d = err_q || credit_ovf || (mc_res_valid && tag_empty) || i_drop || d_drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q       <= CW'(NCREDIT);
            rr_last_q      <= RID_DMEM;
            mc_req_valid_q <= 1'b0;
            mc_req_q       <= '0;
            mc_req_data_q  <= '0;
            i_ret_valid_q  <= 1'b0;
            d_ret_valid_q  <= 1'b0;
            ret_tid_q      <= '0;
            ret_write_q    <= 1'b0;
            ret_data_q     <= '0;
            err_q          <= 1'b0;
        end else begin
            credit_q       <= credit_d;
            rr_last_q      <= rr_last_d;
            mc_req_valid_q <= mc_req_valid_d;
            mc_req_q       <= mc_req_d;
            mc_req_data_q  <= mc_req_data_d;
            i_ret_valid_q  <= i_ret_valid_d;
            d_ret_valid_q  <= d_ret_valid_d;
            ret_tid_q      <= ret_tid_d;
            ret_write_q    <= ret_write_d;
            ret_data_q     <= ret_data_d;
            err_q          <= err_d;
        end
    end

    // Index and parity travel with the tag for downstream fill logic; not needed here.
    assign unused_tag_bits = ^{tag_head.ret_index, tag_head.parity};

    assign mc_req_valid = mc_req_valid_q;
    assign mc_req       = mc_req_q;
    assign mc_req_data  = mc_req_data_q;
    assign i_ret_valid  = i_ret_valid_q;
    assign d_ret_valid  = d_ret_valid_q;
    assign ret_tid      = ret_tid_q;
    assign ret_write    = ret_write_q;
    assign ret_data     = ret_data_q;
    assign err          = err_q;

endmodule

// File: tb/tb_mem_req_arb.sv
// Self-checking bench for mem_req_arb: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_mem_req_arb;
    import mem_req_arb_pkg::*;

    localparam int unsigned NCREDIT  = 4;
    localparam int unsigned TAGDEPTH = 8;

    iu_clk_type            gclk;
    logic                  rst;
    logic                  i_req_valid, d_req_valid;
    imem_req_addr_buf_type i_req;
    dmem_req_addr_buf_type d_req;
    imem_req_data_buf_type i_req_data;
    dmem_req_data_buf_type d_req_data;
    logic                  i_req_ready, d_req_ready;
    logic                  mc_req_valid;
    mem_arb_cmd_type       mc_req;
    dmem_req_data_buf_type mc_req_data;
    logic                  mc_credit, mc_res_valid;
    cache_data_type        mc_res_data;
    logic                  i_ret_valid, d_ret_valid;
    logic [NTHREADIDMSB:0] ret_tid;
    logic                  ret_write;
    cache_data_type        ret_data;
    logic                  err;

    mem_req_arb #(
        .NCREDIT  (NCREDIT),
        .TAGDEPTH (TAGDEPTH)
    ) dut (
        .gclk         (gclk),
        .rst          (rst),
        .i_req_valid  (i_req_valid),
        .i_req        (i_req),
        .i_req_data   (i_req_data),
        .i_req_ready  (i_req_ready),
        .d_req_valid  (d_req_valid),
        .d_req        (d_req),
        .d_req_data   (d_req_data),
        .d_req_ready  (d_req_ready),
        .mc_req_valid (mc_req_valid),
        .mc_req       (mc_req),
        .mc_req_data  (mc_req_data),
        .mc_credit    (mc_credit),
        .mc_res_valid (mc_res_valid),
        .mc_res_data  (mc_res_data),
        .i_ret_valid  (i_ret_valid),
        .d_ret_valid  (d_ret_valid),
        .ret_tid      (ret_tid),
        .ret_write    (ret_write),
        .ret_data     (ret_data),
        .err          (err)
    );

    initial gclk.clk = 1'b0;
    always #5 gclk.clk = ~gclk.clk;

    // Reference model state: free credits, outstanding tags, last winner.
    typedef struct {
        bit       rid;
        bit [2:0] tid;
        bit       we;
    } tag_t;

    tag_t m_tags[$];
    int   m_cred;
    bit   m_last;
    bit   m_err;
    int   total = 0;
    int   bad   = 0;
    int   pend_cred, pend_res;
    bit   g_i_acc, g_d_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic even_par(input logic we, input logic [2:0] tid, input logic [31:0] addr);
        return ^{we, tid, addr};
    endfunction

    task automatic set_i(input logic we, input logic [2:0] tid, input logic [31:0] addr);
        i_req.we     = we;
        i_req.tid    = tid;
        i_req.addr   = addr;
        i_req.parity = even_par(we, tid, addr);
        i_req_data   = {$urandom, $urandom};
    endtask

    task automatic set_d(input logic we, input logic [2:0] tid, input logic [31:0] addr);
        d_req.we     = we;
        d_req.tid    = tid;
        d_req.addr   = addr;
        d_req.parity = even_par(we, tid, addr);
        d_req_data   = {$urandom, $urandom};
    endtask

    // One clock of the design vs. the model. Inputs must already be driven.
    task automatic step();
        bit ig, dg, ibad, dbad, idrop, ddrop, can, gnt;
        bit e_rid, e_we, e_iret, e_dret, e_wr;
        logic [2:0]  e_tid, e_rtid;
        logic [31:0] e_addr;
        logic [63:0] e_wdata, e_rdata;
        tag_t t;
        #1;
        ibad = 1'b0;
        dbad = 1'b0;
`ifdef MEMARB_PARITY_CHK_EN
        ibad = (i_req.parity != even_par(i_req.we, i_req.tid, i_req.addr));
        dbad = (d_req.parity != even_par(d_req.we, d_req.tid, d_req.addr));
`endif
        can = (m_cred > 0) && (m_tags.size() < int'(TAGDEPTH));
        ig  = 1'b0;
        dg  = 1'b0;
        if (can && i_req_valid && !ibad && d_req_valid && !dbad) begin
            if (m_last) ig = 1'b1; else dg = 1'b1;
        end else if (can && i_req_valid && !ibad) begin
            ig = 1'b1;
        end else if (can && d_req_valid && !dbad) begin
            dg = 1'b1;
        end
        idrop = i_req_valid && ibad;
        ddrop = d_req_valid && dbad;
        gnt   = ig || dg;
        g_i_acc = i_req_ready;
        g_d_acc = d_req_ready;
        check("i_req_ready", 64'(i_req_ready), 64'(ig || idrop));
        check("d_req_ready", 64'(d_req_ready), 64'(dg || ddrop));

        e_rid   = dg;
        e_tid   = dg ? d_req.tid : i_req.tid;
        e_addr  = dg ? d_req.addr : i_req.addr;
        e_we    = dg ? d_req.we : i_req.we;
        e_wdata = dg ? d_req_data : i_req_data;
        if (gnt) m_last = dg;

        if (mc_credit && !gnt && m_cred == int'(NCREDIT)) m_err = 1'b1;
        else m_cred = m_cred + int'(mc_credit) - int'(gnt);

        e_iret  = 1'b0;
        e_dret  = 1'b0;
        e_rtid  = '0;
        e_wr    = 1'b0;
        e_rdata = mc_res_data;
        if (mc_res_valid) begin
            if (m_tags.size() == 0) begin
                m_err = 1'b1;
            end else begin
                t      = m_tags.pop_front();
                e_iret = !t.rid;
                e_dret = t.rid;
                e_rtid = t.tid;
                e_wr   = t.we;
            end
        end
        if (gnt) begin
            t.rid = e_rid;
            t.tid = e_tid;
            t.we  = e_we;
            m_tags.push_back(t);
            pend_cred++;
            pend_res++;
        end
        if (idrop || ddrop) m_err = 1'b1;

        @(posedge gclk.clk);
        #1;
        check("mc_req_valid", 64'(mc_req_valid), 64'(gnt));
        if (gnt) begin
            check("mc_req.rid", 64'(mc_req.rid), 64'(e_rid));
            check("mc_req.tid", 64'(mc_req.tid), 64'(e_tid));
            check("mc_req.addr", 64'(mc_req.addr), 64'(e_addr));
            check("mc_req.we", 64'(mc_req.we), 64'(e_we));
            check("mc_req_data", mc_req_data, e_wdata);
        end
        check("i_ret_valid", 64'(i_ret_valid), 64'(e_iret));
        check("d_ret_valid", 64'(d_ret_valid), 64'(e_dret));
        if (e_iret || e_dret) begin
            check("ret_tid", 64'(ret_tid), 64'(e_rtid));
            check("ret_write", 64'(ret_write), 64'(e_wr));
            if (!e_wr) check("ret_data", ret_data, e_rdata);
        end
        check("err", 64'(err), 64'(m_err));
    endtask

    // Reset with requests pending; nothing may be accepted or reported.
    task automatic do_reset();
        rst          = 1'b1;
        i_req_valid  = 1'b1;
        d_req_valid  = 1'b1;
        mc_credit    = 1'b0;
        mc_res_valid = 1'b0;
        mc_res_data  = '0;
        set_i(1'b0, 3'd0, 32'h0);
        set_d(1'b0, 3'd0, 32'h0);
        repeat (2) @(posedge gclk.clk);
        #1;
        check("rst i_req_ready", 64'(i_req_ready), 64'(0));
        check("rst d_req_ready", 64'(d_req_ready), 64'(0));
        check("rst mc_req_valid", 64'(mc_req_valid), 64'(0));
        check("rst i_ret_valid", 64'(i_ret_valid), 64'(0));
        check("rst d_ret_valid", 64'(d_ret_valid), 64'(0));
        check("rst err", 64'(err), 64'(0));
        rst         = 1'b0;
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        m_tags.delete();
        m_cred    = int'(NCREDIT);
        m_last    = 1'b1;
        m_err     = 1'b0;
        pend_cred = 0;
        pend_res  = 0;
    endtask

    initial begin
        rst = 1'b1;
        do_reset();

        // 1: single imem read, tid 3
        i_req_valid = 1'b1;
        set_i(1'b0, 3'd3, 32'h0000_1040);
        step();
        check("t1 ready", 64'(g_i_acc), 64'(1));
        check("t1 rid", 64'(mc_req.rid), 64'(0));
        check("t1 tid", 64'(mc_req.tid), 64'(3));
        i_req_valid = 1'b0;
        step();
        check("t1 one-shot", 64'(mc_req_valid), 64'(0));
        // three more credits remain: three accepted, fourth held
        i_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_i(1'b0, 3'(k), 32'h100 * k);
            step();
        end
        check("t1 credits=3", 64'(g_i_acc), 64'(0));

        // 2: both sides always requesting, credit returned every cycle
        do_reset();
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        mc_credit   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_i(1'b0, 3'd1, 32'h40 * k);
            set_d(1'b1, 3'd2, 32'h80 * k);
            step();
            check("t2 alternate", 64'(mc_req.rid), 64'(k % 2));
        end

        // 3: dmem only, credits exhausted then one credit pulse
        do_reset();
        d_req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_d(1'b0, 3'(k), 32'h40 * k);
            step();
            check("t3 ready", 64'(g_d_acc), 64'(k < 4));
        end
        mc_credit = 1'b1;
        step();
        check("t3 held on credit cycle", 64'(g_d_acc), 64'(0));
        mc_credit = 1'b0;
        step();
        check("t3 issue after credit", 64'(mc_req_valid), 64'(1));

        // 4: imem read tid 1, dmem write tid 5, then two in-order results
        do_reset();
        i_req_valid = 1'b1;
        set_i(1'b0, 3'd1, 32'h2000);
        step();
        i_req_valid = 1'b0;
        d_req_valid = 1'b1;
        set_d(1'b1, 3'd5, 32'h3040);
        step();
        d_req_valid  = 1'b0;
        mc_res_valid = 1'b1;
        mc_res_data  = 64'hDEAD_BEEF_0123_4567;
        step();
        check("t4 i_ret", 64'(i_ret_valid), 64'(1));
        check("t4 tid1", 64'(ret_tid), 64'(1));
        mc_res_data = 64'h0;
        step();
        check("t4 d_ret", 64'(d_ret_valid), 64'(1));
        check("t4 tid5 write", 64'({ret_tid, ret_write}), 64'({3'd5, 1'b1}));
        mc_res_valid = 1'b0;
        step();

        // 5: credit + grant at credits=2 leaves 2; pop on empty sets err
        do_reset();
        d_req_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_d(1'b0, 3'(k), 32'h40 * k);
            step();
        end
        mc_credit = 1'b1;
        step();
        mc_credit = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check("t5 credits stayed 2", 64'(g_d_acc), 64'(0));
        do_reset();
        mc_res_valid = 1'b1;
        step();
        mc_res_valid = 1'b0;
        step();
        check("t5 sticky err", 64'(err), 64'(1));

`ifdef MEMARB_PARITY_CHK_EN
        // 6: flipped parity is acknowledged and dropped
        do_reset();
        d_req_valid = 1'b1;
        set_d(1'b0, 3'd2, 32'h4000);
        d_req.parity = ~d_req.parity;
        step();
        check("t6 dropped", 64'(mc_req_valid), 64'(0));
        d_req_valid = 1'b0;
        i_req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_i(1'b0, 3'(k), 32'h40 * k);
            step();
        end
        check("t6 credits kept", 64'(g_i_acc), 64'(0));
        i_req_valid = 1'b0;
`endif

        // Random traffic with a well-behaved memctrl
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (!i_req_valid || g_i_acc) begin
                i_req_valid = ($urandom_range(0, 3) != 0);
                set_i(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFC0);
            end
            if (!d_req_valid || g_d_acc) begin
                d_req_valid = ($urandom_range(0, 3) != 0);
                set_d(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFC0);
            end
            mc_credit = (pend_cred > 0) && ($urandom_range(0, 2) == 0);
            if (mc_credit) pend_cred--;
            mc_res_valid = (pend_res > 0) && ($urandom_range(0, 2) == 0);
            if (mc_res_valid) pend_res--;
            mc_res_data = {$urandom, $urandom};
            g_i_acc = 1'b0;
            g_d_acc = 1'b0;
            step();
            // occasional reset mid-flight
            if (c == 300) begin
                do_reset();
                g_i_acc = 1'b0;
                g_d_acc = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
